// File: rtl/i2s_pkg.sv
// Shared defaults, lrck polarity and slot helper for the I2S master and its clock generator.
package i2s_pkg;

  localparam int DEF_DW       = 24;
  localparam int DEF_SLOTS    = 32;
  localparam int DEF_MSB_SLOT = 8;
  localparam int DEF_BCLK_DIV = 8;

  localparam logic LEFT = 1'b1;

  // Slot position inside the current half-frame.
  function automatic int slot_of(input int bit_cnt, input int slots);
    return bit_cnt % slots;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Bit/word clock generator: divides AMSCK into bclk, tracks the frame bit counter and lrck.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int SLOTS    = DEF_SLOTS,
  parameter int BCLK_DIV = DEF_BCLK_DIV,
  localparam int DIVW    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1,
  localparam int BW      = $clog2(2 * SLOTS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          bclk_o,
  output logic          lrck_o,
  output logic          rise_o,
  output logic          fall_o,
  output logic [BW-1:0] bit_cnt_o,
  output logic [BW-1:0] bit_nxt_o
);

  logic [DIVW-1:0] div_q, div_d;
  logic            bclk_q, bclk_d;
  logic            lrck_q, lrck_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [BW-1:0]   bit_nxt_s;
  logic            wrap_s;

  assign wrap_s    = (div_q == DIVW'(BCLK_DIV - 1));
  assign bit_nxt_s = (bit_q == BW'(2 * SLOTS - 1)) ? '0 : bit_q + 1'b1;

  // Divider, bclk toggle and fall-time advance of the frame counter.
  always_comb begin
    div_d  = div_q;
    bclk_d = bclk_q;
    bit_d  = bit_q;
    lrck_d = lrck_q;
    if (wrap_s) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      div_d  = div_q + 1'b1;
      bclk_d = bclk_q;
    end
    if (wrap_s && bclk_q) begin
      bit_d  = bit_nxt_s;
      lrck_d = (int'(bit_nxt_s) < SLOTS) ? LEFT : ~LEFT;
    end else begin
      bit_d  = bit_q;
      lrck_d = lrck_q;
    end
  end

  // Clock-generator state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
      lrck_q <= 1'b0;
      bit_q  <= BW'(2 * SLOTS - 1);
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
      lrck_q <= lrck_d;
      bit_q  <= bit_d;
    end
  end

  assign bclk_o    = bclk_q;
  assign lrck_o    = lrck_q;
  assign rise_o    = wrap_s & ~bclk_q;
  assign fall_o    = wrap_s & bclk_q;
  assign bit_cnt_o = bit_q;
  assign bit_nxt_o = bit_nxt_s;

endmodule

// File: rtl/i2s_master.sv
// Codec-side I2S master: generates bclk/lrck, serializes held L/R pairs onto sdout and
// deserializes sdin into parallel words with per-channel valid pulses.
module i2s_master
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = DEF_BCLK_DIV,
  parameter int SLOTS    = DEF_SLOTS,
  parameter int DW       = DEF_DW,
  parameter int MSB_SLOT = DEF_MSB_SLOT,
  localparam int BW      = $clog2(2 * SLOTS)
) (
  input  logic          AMSCK,
  input  logic          rst,
  input  logic [DW-1:0] tx_l,
  input  logic [DW-1:0] tx_r,
  input  logic          tx_wr,
  output logic          tx_req,
  output logic          underrun,
  output logic          bclk,
  output logic          lrck,
  output logic          sdout,
  input  logic          sdin,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid_l,
  output logic          rx_valid_r
);

  logic          rise_s, fall_s, lrck_s;
  logic [BW-1:0] bit_cnt_s, bit_nxt_s;
  int            slot_cur_s, slot_nxt_s;
  logic          load_l_s, load_r_s;
  logic [DW-1:0] sh_src_s;

  logic [DW-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic          hold_full_q, hold_full_d;
  logic [DW-1:0] stg_r_q, stg_r_d;
  logic [DW-1:0] tx_sh_q, tx_sh_d;
  logic          sdout_q, sdout_d;
  logic          tx_req_q, tx_req_d;
  logic          under_q, under_d;
  logic          sdin_q;
  logic          armed_q, armed_d;
  logic [DW-1:0] rx_sh_q, rx_sh_d;
  logic [DW-1:0] rx_data_q, rx_data_d;
  logic          rx_vl_q, rx_vl_d, rx_vr_q, rx_vr_d;

  i2s_clkgen #(
    .SLOTS    (SLOTS),
    .BCLK_DIV (BCLK_DIV)
  ) u_clkgen (
    .clk_i     (AMSCK),
    .rst_i     (rst),
    .bclk_o    (bclk),
    .lrck_o    (lrck_s),
    .rise_o    (rise_s),
    .fall_o    (fall_s),
    .bit_cnt_o (bit_cnt_s),
    .bit_nxt_o (bit_nxt_s)
  );

  assign slot_cur_s = slot_of(int'(bit_cnt_s), SLOTS);
  assign slot_nxt_s = slot_of(int'(bit_nxt_s), SLOTS);
  assign load_l_s   = fall_s && (bit_nxt_s == '0);
  assign load_r_s   = fall_s && (int'(bit_nxt_s) == SLOTS);

  // Holding registers, shift-register loads and serial output on bclk falls.
  always_comb begin
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q;
    stg_r_d     = stg_r_q;
    tx_sh_d     = tx_sh_q;
    sdout_d     = sdout_q;
    tx_req_d    = 1'b0;
    under_d     = under_q;
    sh_src_s    = tx_sh_q;

    if (load_l_s) begin
      sh_src_s = hold_l_q;
      stg_r_d  = hold_r_q;
      tx_req_d = 1'b1;
      under_d  = under_q | ~hold_full_q;
    end else if (load_r_s) begin
      sh_src_s = stg_r_q;
    end else begin
      sh_src_s = tx_sh_q;
    end

    if (fall_s && (slot_nxt_s >= MSB_SLOT)) begin
      sdout_d = sh_src_s[DW-1];
      tx_sh_d = sh_src_s << 1;
    end else if (fall_s) begin
      sdout_d = 1'b0;
      tx_sh_d = sh_src_s;
    end else begin
      sdout_d = sdout_q;
      tx_sh_d = tx_sh_q;
    end

    // A write landing on a load cycle survives: the load already took the old pair.
    if (tx_wr) begin
      hold_l_d    = tx_l;
      hold_r_d    = tx_r;
      hold_full_d = 1'b1;
    end else begin
      hold_l_d    = hold_l_q;
      hold_r_d    = hold_r_q;
      hold_full_d = hold_full_q & ~load_l_s;
    end
  end

  // Receive shifter; the rise before the first fall after reset belongs to no frame.
  always_comb begin
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    rx_vl_d   = 1'b0;
    rx_vr_d   = 1'b0;
    armed_d   = armed_q | fall_s;
    if (rise_s && armed_q && (slot_cur_s >= MSB_SLOT)) begin
      rx_sh_d = {rx_sh_q[DW-2:0], sdin_q};
      if (slot_cur_s == SLOTS - 1) begin
        rx_data_d = {rx_sh_q[DW-2:0], sdin_q};
        rx_vl_d   = (lrck_s == LEFT);
        rx_vr_d   = (lrck_s != LEFT);
      end else begin
        rx_data_d = rx_data_q;
      end
    end else begin
      rx_sh_d = rx_sh_q;
    end
  end

  // Datapath state registers.
  always_ff @(posedge AMSCK or posedge rst) begin
    if (rst) begin
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      stg_r_q     <= '0;
      tx_sh_q     <= '0;
      sdout_q     <= 1'b0;
      tx_req_q    <= 1'b0;
      under_q     <= 1'b0;
      sdin_q      <= 1'b0;
      armed_q     <= 1'b0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      rx_vl_q     <= 1'b0;
      rx_vr_q     <= 1'b0;
    end else begin
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      hold_full_q <= hold_full_d;
      stg_r_q     <= stg_r_d;
      tx_sh_q     <= tx_sh_d;
      sdout_q     <= sdout_d;
      tx_req_q    <= tx_req_d;
      under_q     <= under_d;
      sdin_q      <= sdin;
      armed_q     <= armed_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      rx_vl_q     <= rx_vl_d;
      rx_vr_q     <= rx_vr_d;
    end
  end

  assign lrck       = lrck_s;
  assign sdout      = sdout_q;
  assign tx_req     = tx_req_q;
  assign underrun   = under_q;
  assign rx_data    = rx_data_q;
  assign rx_valid_l = rx_vl_q;
  assign rx_valid_r = rx_vr_q;

endmodule

// File: tb/tb_i2s_master.sv
// Self-checking bench for i2s_master: sdout looped back to sdin, serial monitor decodes
// half-frames, and a frame-level model predicts which pair each frame carries.
module tb_i2s_master;

  logic        AMSCK = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] tx_l = 24'h0, tx_r = 24'h0;
  logic        tx_wr = 1'b0;
  logic        tx_req, underrun, bclk, lrck, sdout, sdin;
  logic [23:0] rx_data;
  logic        rx_valid_l, rx_valid_r;

  int n_chk = 0;
  int n_fail = 0;

  logic [25:0] tx_q[$];
  logic [24:0] rx_q[$];
  logic [24:0] exp_q[$];

  logic [23:0] mdl_l, mdl_r;
  logic        mdl_full, mdl_under;

  always #5 AMSCK = ~AMSCK;
  assign sdin = sdout;

  i2s_master dut (
    .AMSCK(AMSCK), .rst(rst), .tx_l(tx_l), .tx_r(tx_r), .tx_wr(tx_wr),
    .tx_req(tx_req), .underrun(underrun), .bclk(bclk), .lrck(lrck),
    .sdout(sdout), .sdin(sdin), .rx_data(rx_data),
    .rx_valid_l(rx_valid_l), .rx_valid_r(rx_valid_r)
  );

  // Serial monitor: decodes sdout at bclk rises into half-frames, collects rx pulses.
  logic        m_pb = 1'b0, m_ps = 1'b0, m_started = 1'b0, m_lr = 1'b0, m_zero = 1'b1;
  logic [23:0] m_word = 24'h0;
  int          m_slot = 0;
  always @(negedge AMSCK) begin
    if (rst) begin
      m_started = 1'b0;
      m_slot = 0;
      m_pb = 1'b0;
      m_ps = 1'b0;
    end else begin
      if (sdout !== m_ps) begin
        n_chk++;
        if (!(m_pb && !bclk)) begin
          n_fail++;
          $display("FAIL sdout_timing: sdout became %b while bclk went %b->%b, required a bclk fall", sdout, m_pb, bclk);
        end
      end
      if (rx_valid_l || rx_valid_r) begin
        n_chk++;
        if (rx_valid_l && rx_valid_r) begin
          n_fail++;
          $display("FAIL rx_valid_excl: both valids high, required one");
        end
        rx_q.push_back({rx_valid_l, rx_data});
      end
      if (bclk && !m_pb && (m_started || lrck)) begin
        if (!m_started || lrck !== m_lr) begin
          m_started = 1'b1;
          m_lr = lrck;
          m_slot = 0;
          m_word = 24'h0;
          m_zero = 1'b1;
        end
        if (m_slot < 8) m_zero = m_zero & (sdout == 1'b0);
        else m_word = {m_word[22:0], sdout};
        m_slot++;
        if (m_slot == 32) begin
          tx_q.push_back({m_zero, m_lr, m_word});
          m_slot = 0;
        end
      end
      m_pb = bclk;
      m_ps = sdout;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    tx_wr = 1'b0;
    repeat (3) begin
      @(posedge AMSCK); #1;
      n_chk++;
      if ({bclk, lrck, sdout, tx_req, underrun, rx_data, rx_valid_l, rx_valid_r} !== 31'h0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %h, required all zero",
                 {bclk, lrck, sdout, tx_req, underrun, rx_data, rx_valid_l, rx_valid_r});
      end
    end
    tx_q.delete(); rx_q.delete(); exp_q.delete();
    mdl_l = 24'h0; mdl_r = 24'h0; mdl_full = 1'b0; mdl_under = 1'b0;
    rst = 1'b0;
  endtask

  task automatic model_write(input logic [23:0] l, input logic [23:0] r);
    tx_l = l; tx_r = r; tx_wr = 1'b1;
    @(posedge AMSCK); #1;
    tx_wr = 1'b0;
    mdl_l = l; mdl_r = r; mdl_full = 1'b1;
  endtask

  // Wait for the next frame start and advance the frame model.
  task automatic wait_frame();
    logic prev_lr, got;
    prev_lr = lrck;
    got = 1'b0;
    for (int k = 0; k < 1100; k++) begin
      @(posedge AMSCK); #1;
      if (tx_req) begin
        got = 1'b1;
        break;
      end
      prev_lr = lrck;
    end
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL frame_start: tx_req absent for 1100 cycles, required a pulse");
    end else if (!(lrck === 1'b1 && prev_lr === 1'b0)) begin
      n_fail++;
      $display("FAIL tx_req_align: lrck %b (prev %b) at tx_req, required rising to 1", lrck, prev_lr);
    end
    if (!mdl_full) mdl_under = 1'b1;
    exp_q.push_back({1'b1, mdl_l});
    exp_q.push_back({1'b0, mdl_r});
    mdl_full = 1'b0;
    n_chk++;
    if (underrun !== mdl_under) begin
      n_fail++;
      $display("FAIL underrun: got %b, required %b", underrun, mdl_under);
    end
  endtask

  task automatic test_reset_clocking();
    int   last_rise, rises, falls, lr_edges;
    logic pb, pl;
    do_reset();
    last_rise = -1; rises = 0; falls = 0; lr_edges = 0; pb = 1'b0; pl = 1'b0;
    for (int c = 1; c <= 1100; c++) begin
      @(negedge AMSCK);
      if (bclk && !pb) begin
        if (last_rise >= 0) begin
          n_chk++;
          if (c - last_rise != 16) begin
            n_fail++;
            $display("FAIL bclk_period: got %0d cycles, required 16", c - last_rise);
          end
        end
        last_rise = c;
        rises++;
      end
      if (!bclk && pb) falls++;
      if (lrck !== pl) begin
        n_chk++;
        if (!(pb && !bclk)) begin
          n_fail++;
          $display("FAIL lrck_edge: lrck changed with bclk %b->%b, required a bclk fall", pb, bclk);
        end
        n_chk++;
        if (lr_edges == 0 && !(lrck === 1'b1 && falls == 1)) begin
          n_fail++;
          $display("FAIL lrck_first: lrck %b after %0d falls, required 1 after 1", lrck, falls);
        end else if (lr_edges != 0 && rises != 32) begin
          n_fail++;
          $display("FAIL lrck_phase: got %0d bclk periods, required 32", rises);
        end
        lr_edges++;
        rises = 0;
      end
      pb = bclk;
      pl = lrck;
    end
    n_chk++;
    if (lr_edges != 3) begin
      n_fail++;
      $display("FAIL lrck_edge_count: got %0d, required 3", lr_edges);
    end
  endtask

  // Pattern, loopback, underrun and random back-to-back frames.
  task automatic test_tx_stream();
    logic [23:0] wl[7], wr[7];
    logic        we[7];
    logic [25:0] t;
    logic [24:0] e, r;
    wl[0] = 24'h885511; wr[0] = 24'h123456; we[0] = 1'b1;
    wl[1] = 24'h654321; wr[1] = 24'h40724F; we[1] = 1'b1;
    wl[2] = 24'h0;      wr[2] = 24'h0;      we[2] = 1'b0;
    for (int i = 3; i < 7; i++) begin
      wl[i] = 24'($urandom); wr[i] = 24'($urandom); we[i] = 1'b1;
    end
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (we[i]) model_write(wl[i], wr[i]);
      wait_frame();
    end
    for (int w = 0; w < 4000 && (tx_q.size() < exp_q.size() || rx_q.size() < exp_q.size()); w++)
      @(posedge AMSCK);
    n_chk++;
    if (tx_q.size() < exp_q.size() || rx_q.size() < exp_q.size()) begin
      n_fail++;
      $display("FAIL stream_wait: tx %0d rx %0d half-frames, required %0d", tx_q.size(), rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && tx_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); t = tx_q.pop_front(); r = rx_q.pop_front();
      n_chk++;
      if (t !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL stream_tx: got zero/lr/word %h, required %h", t, {1'b1, e});
      end
      n_chk++;
      if (r !== e) begin
        n_fail++;
        $display("FAIL stream_rx: got lr/word %h, required %h", r, e);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [23:0] p0l, p0r, p1l, p1r;
    logic [25:0] t;
    logic [24:0] e;
    p0l = 24'($urandom); p0r = 24'($urandom); p1l = 24'($urandom); p1r = 24'($urandom);
    do_reset();
    model_write(p0l, p0r);
    wait_frame();
    model_write(p1l, p1r);
    repeat (1022) @(posedge AMSCK);
    #1;
    tx_l = 24'h000001; tx_r = 24'h85457A; tx_wr = 1'b1;
    @(posedge AMSCK); #1;
    tx_wr = 1'b0;
    n_chk++;
    if (tx_req !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_align: tx_req %b on the write cycle, required 1", tx_req);
    end
    exp_q.push_back({1'b1, mdl_l});
    exp_q.push_back({1'b0, mdl_r});
    mdl_l = 24'h000001; mdl_r = 24'h85457A; mdl_full = 1'b1;
    wait_frame();
    for (int w = 0; w < 3000 && tx_q.size() < exp_q.size(); w++) @(posedge AMSCK);
    n_chk++;
    if (tx_q.size() < exp_q.size()) begin
      n_fail++;
      $display("FAIL simul_wait: tx %0d half-frames, required %0d", tx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && tx_q.size() > 0) begin
      e = exp_q.pop_front(); t = tx_q.pop_front();
      n_chk++;
      if (t !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL simul_tx: got zero/lr/word %h, required %h", t, {1'b1, e});
      end
    end
  endtask

  task automatic test_midframe_reset();
    logic [24:0] e, r;
    do_reset();
    model_write(24'($urandom), 24'($urandom));
    wait_frame();
    repeat (320) @(posedge AMSCK);
    #1;
    n_chk++;
    if (rx_q.size() != 0) begin
      n_fail++;
      $display("FAIL midframe_rx_pre: got %0d rx pulses, required 0", rx_q.size());
    end
    do_reset();
    wait_frame();
    n_chk++;
    if (sdout !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_sdout: got %b at restart, required 0", sdout);
    end
    for (int w = 0; w < 3000 && rx_q.size() < 2; w++) @(posedge AMSCK);
    n_chk++;
    if (rx_q.size() < 2) begin
      n_fail++;
      $display("FAIL midframe_wait: got %0d rx pulses, required 2", rx_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      n_chk++;
      if (r !== e) begin
        n_fail++;
        $display("FAIL midframe_rx: got lr/word %h, required %h", r, e);
      end
    end
  endtask

  initial begin
    #2;
    test_reset_clocking();
    test_tx_stream();
    test_simultaneous();
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
